// File: rtl/lp805x_schedce_if.sv
// Bundle between lp805x_schedfs (master) and the clock-enable generator (slave).
interface lp805x_schedce_if #(
  parameter int IDX_W = 3
) ();
  logic             enable;
  logic             load;
  logic [IDX_W-1:0] index;
  logic             ce;
  logic [IDX_W-1:0] cur_index;
  logic             pending;
  logic             done;

  modport master (
    output enable, load, index,
    input  ce, cur_index, pending, done
  );

  modport slave (
    input  enable, load, index,
    output ce, cur_index, pending, done
  );
endinterface

// File: rtl/lp805x_schedce.sv
// Frequency-scaling clock-enable generator: emits a one-cycle ce pulse every
// 2^cur_index cycles and defers ratio switches to the next period boundary.
module lp805x_schedce #(
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 7,
  parameter int RESET_IDX = 0
) (
  input logic              clk,
  input logic              rst,
  lp805x_schedce_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RESET_IDX);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ce_reg;
  logic             pending_reg;
  logic             done_reg;
  logic [IDX_W-1:0] cur_idx_reg;
  logic [IDX_W-1:0] pend_idx_reg;

  logic [CNT_W-1:0] ratio_m1;
  logic             boundary;

  // Terminal count comes from the ratio in force only; a queued index never
  // shortens or stretches the period already running.
  always_comb begin
    ratio_m1 = CNT_W'((32'd1 << cur_idx_reg) - 32'd1);
    boundary = (cnt_reg == ratio_m1);
  end

  // Period counter, ce pulse and index-switch state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ce_reg       <= 1'b0;
      pending_reg  <= 1'b0;
      done_reg     <= 1'b0;
      cur_idx_reg  <= RST_IDX;
      pend_idx_reg <= RST_IDX;
    end else begin
      done_reg <= 1'b0;
      if (!bus.enable) begin
        // Stopped: counter frozen, and any switch takes effect right away
        // since there is no running period to protect.
        ce_reg    <= 1'b0;
        state_reg <= IDLE;
        if (state_reg == PEND) begin
          cur_idx_reg <= bus.load ? bus.index : pend_idx_reg;
          cnt_reg     <= '0;
          pending_reg <= 1'b0;
          done_reg    <= 1'b1;
        end else if (bus.load) begin
          cur_idx_reg <= bus.index;
          cnt_reg     <= '0;
          done_reg    <= 1'b1;
        end
      end else if ((state_reg == IDLE) && bus.load) begin
        // A load on the restart edge is still an idle-time switch: apply it
        // and begin the new period from zero on the following edge.
        cur_idx_reg <= bus.index;
        cnt_reg     <= '0;
        done_reg    <= 1'b1;
        ce_reg      <= 1'b0;
        state_reg   <= RUN;
      end else begin
        ce_reg  <= boundary;
        cnt_reg <= boundary ? '0 : cnt_reg + CNT_W'(1);
        if (state_reg == PEND) begin
          // Last request wins, including one arriving on the boundary edge.
          if (boundary) begin
            cur_idx_reg <= bus.load ? bus.index : pend_idx_reg;
            pending_reg <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= RUN;
          end else if (bus.load) begin
            pend_idx_reg <= bus.index;
          end
        end else begin
          state_reg <= RUN;
          if (bus.load) begin
            if (boundary) begin
              cur_idx_reg <= bus.index;
              done_reg    <= 1'b1;
            end else begin
              pend_idx_reg <= bus.index;
              pending_reg  <= 1'b1;
              state_reg    <= PEND;
            end
          end
        end
      end
    end
  end

  assign bus.ce        = ce_reg;
  assign bus.cur_index = cur_idx_reg;
  assign bus.pending   = pending_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_lp805x_schedce.sv
// Bench for lp805x_schedce: period/phase model compared every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_lp805x_schedce;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lp805x_schedce_if #(.IDX_W(3)) bus ();

  lp805x_schedce #(.IDX_W(3), .CNT_W(7), .RESET_IDX(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: phase within the current period, ratio in force, queued request.
  int m_phase;
  int m_cur;
  bit m_has_req;
  int m_req;
  bit m_ce;
  bit m_done;
  bit m_stopped;

  // Reference model advanced on each clock edge from the sampled inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_cur = 0; m_has_req = 0; m_req = 0;
      m_ce = 0; m_done = 0; m_stopped = 1;
    end else begin
      m_done = 0;
      if (!bus.enable) begin
        m_ce = 0;
        if (m_has_req || bus.load) begin
          m_cur = bus.load ? int'(bus.index) : m_req;
          m_phase = 0; m_has_req = 0; m_done = 1;
        end
        m_stopped = 1;
      end else if (m_stopped && bus.load) begin
        m_cur = int'(bus.index); m_phase = 0; m_done = 1; m_ce = 0;
        m_stopped = 0;
      end else begin
        int period;
        bit wrap;
        period = 1 << m_cur;
        m_phase = (m_phase + 1) % period;
        wrap = (m_phase == 0);
        m_ce = wrap;
        m_stopped = 0;
        if (bus.load) begin
          m_req = int'(bus.index);
          if (!wrap) m_has_req = 1;
        end
        if (wrap && (m_has_req || bus.load)) begin
          m_cur = m_req; m_has_req = 0; m_done = 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.ce !== m_ce || int'(bus.cur_index) != m_cur ||
          bus.pending !== m_has_req || bus.done !== m_done) begin
        errors++;
        $display("FAIL model t=%0t got ce=%b cur=%0d pend=%b done=%b required ce=%b cur=%0d pend=%b done=%b",
                 $time, bus.ce, bus.cur_index, bus.pending, bus.done,
                 m_ce, m_cur, m_has_req, m_done);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  // One clock edge with the given inputs; returns at the following negedge.
  task automatic step(input bit en, input bit ld, input int idx);
    bus.enable = en;
    bus.load   = ld;
    bus.index  = 3'(idx);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.enable = 1'b0; bus.load = 1'b0; bus.index = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ce", int'(bus.ce), 0);
    chk("reset_cur", int'(bus.cur_index), 0);
    chk("reset_pending", int'(bus.pending), 0);
    chk("reset_done", int'(bus.done), 0);
    rst = 1'b0;

    // T1: index 2 -> ce on enabled edges 4, 8, 12, single done pulse.
    step(0, 1, 2);
    chk("t1_done", int'(bus.done), 1);
    chk("t1_cur", int'(bus.cur_index), 2);
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 0);
      chk($sformatf("t1_ce_edge%0d", k), int'(bus.ce), (k % 4 == 0) ? 1 : 0);
      n += int'(bus.done);
    end
    chk("t1_extra_done", n, 0);

    // T2: index 0 -> ce held high; dropping enable clears ce next edge.
    step(0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0);
      chk($sformatf("t2_ce_edge%0d", k), int'(bus.ce), 1);
    end
    step(0, 0, 0);
    chk("t2_ce_stopped", int'(bus.ce), 0);
    step(0, 0, 0);
    chk("t2_ce_still_stopped", int'(bus.ce), 0);

    // T3: N=8, load index 1 at cnt=3.
    step(0, 1, 3);
    for (int k = 1; k <= 3; k++) step(1, 0, 0);
    step(1, 1, 1);
    n = int'(bus.pending);
    for (int k = 5; k <= 7; k++) begin
      step(1, 0, 0);
      n += int'(bus.pending);
      chk($sformatf("t3_ce_edge%0d", k), int'(bus.ce), 0);
    end
    step(1, 0, 0);
    chk("t3_pending_cycles", n, 4);
    chk("t3_wrap_ce", int'(bus.ce), 1);
    chk("t3_wrap_done", int'(bus.done), 1);
    chk("t3_wrap_cur", int'(bus.cur_index), 1);
    chk("t3_wrap_pending", int'(bus.pending), 0);
    for (int k = 9; k <= 12; k++) begin
      step(1, 0, 0);
      chk($sformatf("t3_ce_edge%0d", k), int'(bus.ce), (k % 2 == 0) ? 1 : 0);
    end

    // T4: N=16, load 5 then 2 before the boundary -> only 2 applied, one done.
    step(0, 0, 0);
    step(0, 1, 4);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 5);
    chk("t4_cur_during", int'(bus.cur_index), 4);
    step(1, 0, 0);
    step(1, 1, 2);
    n = 0;
    for (int k = 6; k <= 20; k++) begin
      step(1, 0, 0);
      n += int'(bus.done);
      if (k == 16) chk("t4_boundary_ce", int'(bus.ce), 1);
    end
    chk("t4_done_pulses", n, 1);
    chk("t4_cur_after", int'(bus.cur_index), 2);

    // T5: pending switch to 6 applied when enable drops; then 64-cycle period.
    step(0, 0, 0);
    step(0, 1, 3);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 6);
    chk("t5_pending", int'(bus.pending), 1);
    step(0, 0, 0);
    chk("t5_cur", int'(bus.cur_index), 6);
    chk("t5_pending_clear", int'(bus.pending), 0);
    chk("t5_done", int'(bus.done), 1);
    chk("t5_ce", int'(bus.ce), 0);
    n = 0;
    for (int k = 1; k <= 64; k++) begin
      step(1, 0, 0);
      if (bus.ce && n == 0) n = k;
    end
    chk("t5_first_ce_edge", n, 64);

    // T6: index 7, pending request queued, async reset at cnt=50.
    step(0, 0, 0);
    step(0, 1, 7);
    for (int k = 1; k <= 48; k++) step(1, 0, 0);
    step(1, 1, 3);
    step(1, 0, 0);
    chk("t6_pending_before", int'(bus.pending), 1);
    chk("t6_cur_before", int'(bus.cur_index), 7);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_ce", int'(bus.ce), 0);
    chk("t6_async_pending", int'(bus.pending), 0);
    chk("t6_async_cur", int'(bus.cur_index), 0);
    chk("t6_async_done", int'(bus.done), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0);
      chk($sformatf("t6_after_ce%0d", k), int'(bus.ce), 1);
    end
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout reached t=%0t required finish", $time);
    $fatal(1);
  end

endmodule
